// File: rtl/uart_pkg.sv
// Shared constants and launch-FSM encoding for the UART transmit path.
package uart_pkg;

  localparam int BYTE_W       = 8;
  localparam int BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and registered full/empty/level.
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_next;
  logic             do_push;
  logic             do_pop;

  // push/pop are requests; the FIFO ignores a push while full and a pop while empty,
  // judged on the flags as registered before the edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + 1'b1;
    end else if (!do_push && do_pop) begin
      level_next = level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      full  <= (level_next == FULL_LEVEL);
      empty <= (level_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of async_transmitter: buffers CPU writes and launches one frame at a time.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              idle,
  output tx_state_t         dbg_state
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_next;
  logic              launch;
  logic [BYTE_W-1:0] head;

  // Transmitter handshake: tx_start is a single-cycle pulse qualified by tx_data; the
  // transmitter acknowledges by raising tx_busy and the frame is over when tx_busy falls.
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (launch),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    state_next  = state;
    to_cnt_next = to_cnt;
    launch      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          launch      = 1'b1;
          to_cnt_next = '0;
          state_next  = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        // A transmitter that never raises busy lost the pulse; give up on that byte.
        if (tx_busy) begin
          state_next = S_WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          state_next = S_IDLE;
        end else begin
          to_cnt_next = to_cnt + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      to_cnt   <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      to_cnt   <= to_cnt_next;
      tx_start <= launch;
      if (launch) tx_data <= head;
      // Set has priority so an overflow in the clearing cycle is not lost.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign idle      = empty && (state == S_IDLE) && !tx_busy;
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter that holds busy for a fixed frame.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FRAME = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            wr_en   = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            ovf_clr = 1'b0;
  logic            full, empty, overflow, tx_start, tx_busy, idle;
  logic [AW:0]     level;
  logic [7:0]      tx_data;
  tx_state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  int launches = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .idle      (idle),
    .dbg_state (dbg_state)
  );

  // Transmitter model: not reset by rst, like the real async_transmitter.
  logic model_busy   = 1'b0;
  int   busy_cnt     = 0;
  logic model_ignore = 1'b0;
  logic force_busy   = 1'b0;
  assign tx_busy = model_busy | force_busy;

  always @(posedge clk) begin
    if (tx_start && !model_busy && !model_ignore) begin
      model_busy <= 1'b1;
      busy_cnt   <= FRAME;
    end else if (model_busy) begin
      if (busy_cnt == 1) model_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Scoreboard: each launch must carry the oldest accepted byte; pulses never back to back.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst && tx_start) begin
      launches++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected: tx_data=%02h with no byte expected", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL launch_order: tx_data=%02h expected %02h", tx_data, e);
        end
      end
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL start_pulse_width: tx_start high 2 cycles, expected 1");
      end
    end
    prev_start = tx_start;
  end

  // driver tasks
  task automatic wait_idle(input int max_cycles, input string name);
    int n = 0;
    while (!idle && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL %s: idle=%b after %0d cycles, expected 1", name, idle, n);
    end
  endtask

  task automatic write_bytes(input logic [7:0] first, input int n, input logic accept);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = first + 8'(i);
      if (accept) exp_q.push_back(wr_data);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({full, empty, level, overflow, tx_start, tx_data} !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: full=%b empty=%b level=%0d ovf=%b start=%b data=%02h expected 0 1 0 0 0 00",
               full, empty, level, overflow, tx_start, tx_data);
    end
    checks++;
    if (dbg_state !== S_IDLE || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: state=%0d idle=%b expected 0 1", dbg_state, idle);
    end
  endtask

  task automatic test_single();
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (level !== 5'd1 || empty !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL single_queued: level=%0d empty=%b start=%b expected 1 0 0", level, empty, tx_start);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5 || level !== 5'd0 || dbg_state !== S_WAIT_BUSY) begin
      errors++;
      $display("FAIL single_launch: start=%b data=%02h level=%0d state=%0d expected 1 a5 0 1",
               tx_start, tx_data, level, dbg_state);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_end: tx_start=%b expected 0", tx_start);
    end
    wait_idle(FRAME + 10, "single_idle");
    checks++;
    if (tx_data !== 8'hA5 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL single_hold: data=%02h state=%0d expected a5 0", tx_data, dbg_state);
    end
  endtask

  task automatic test_burst();
    int l0 = launches;
    force_busy = 1'b1;
    write_bytes(8'h01, 16, 1'b1);
    checks++;
    if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL burst_full: full=%b level=%0d ovf=%b expected 1 16 0", full, level, overflow);
    end
    force_busy = 1'b0;
    wait_idle(16 * (FRAME + 6), "burst_drain");
    checks++;
    if (launches - l0 !== 16 || empty !== 1'b1) begin
      errors++;
      $display("FAIL burst_count: launches=%0d empty=%b expected 16 1", launches - l0, empty);
    end
  endtask

  task automatic test_overflow();
    force_busy = 1'b1;
    write_bytes(8'h20, 16, 1'b1);
    write_bytes(8'hEE, 1, 1'b0);
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b level=%0d full=%b expected 1 16 1", overflow, level, full);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
    end
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEF;
    @(negedge clk);
    ovf_clr = 1'b0; wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf=%b level=%0d expected 1 16", overflow, level);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    force_busy = 1'b0;
    wait_idle(16 * (FRAME + 6), "ovf_drain");
  endtask

  task automatic test_push_pop();
    force_busy = 1'b1;
    write_bytes(8'h31, 3, 1'b1);
    checks++;
    if (level !== 5'd3) begin
      errors++;
      $display("FAIL pp_level_pre: level=%0d expected 3", level);
    end
    force_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h34; exp_q.push_back(8'h34);
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (level !== 5'd3 || tx_start !== 1'b1 || tx_data !== 8'h31) begin
      errors++;
      $display("FAIL pp_same_cycle: level=%0d start=%b data=%02h expected 3 1 31", level, tx_start, tx_data);
    end
    wait_idle(4 * (FRAME + 6), "pp_drain");
  endtask

  task automatic test_wrap();
    int sent = 0;
    int cyc = 0;
    int l0 = launches;
    logic lvl_bad = 1'b0;
    while (sent < 40 && cyc < 3000) begin
      if (!full) begin
        wr_en = 1'b1; wr_data = 8'h80 + 8'(sent);
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (level > 5'd16) lvl_bad = 1'b1;
    end
    wr_en = 1'b0;
    checks++;
    if (sent !== 40 || lvl_bad !== 1'b0) begin
      errors++;
      $display("FAIL wrap_fill: sent=%0d level_over=%b expected 40 0", sent, lvl_bad);
    end
    wait_idle(18 * (FRAME + 6), "wrap_drain");
    checks++;
    if (launches - l0 !== 40) begin
      errors++;
      $display("FAIL wrap_count: launches=%0d expected 40", launches - l0);
    end
  endtask

  task automatic test_timeout();
    model_ignore = 1'b1;
    wr_en = 1'b1; wr_data = 8'h77; exp_q.push_back(8'h77);
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || dbg_state !== S_WAIT_BUSY) begin
      errors++;
      $display("FAIL to_launch: start=%b state=%0d expected 1 1", tx_start, dbg_state);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dbg_state !== S_WAIT_BUSY) begin
      errors++;
      $display("FAIL to_still_waiting: state=%0d expected 1", dbg_state);
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== S_IDLE || idle !== 1'b1) begin
      errors++;
      $display("FAIL to_expired: state=%0d idle=%b expected 0 1", dbg_state, idle);
    end
    model_ignore = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int l0;
    logic early = 1'b0;
    int n = 0;
    write_bytes(8'h55, 1, 1'b1);
    write_bytes(8'h61, 5, 1'b1);
    checks++;
    if (level !== 5'd5 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL rmf_queued: level=%0d busy=%b expected 5 1", level, tx_busy);
    end
    repeat (6) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || tx_start !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL rmf_flushed: level=%0d empty=%b start=%b state=%0d expected 0 1 0 0",
               level, empty, tx_start, dbg_state);
    end
    l0 = launches;
    write_bytes(8'h3C, 1, 1'b1);
    while (tx_busy && n < 2 * FRAME) begin
      if (tx_start) early = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (early !== 1'b0 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rmf_guard: early_start=%b busy=%b expected 0 0", early, tx_busy);
    end
    wait_idle(FRAME + 10, "rmf_relaunch");
    checks++;
    if (launches - l0 !== 1) begin
      errors++;
      $display("FAIL rmf_relaunch_count: launches=%0d expected 1", launches - l0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_push_pop();
    test_wrap();
    test_timeout();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL leftover_bytes: %0d bytes never launched, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
